adc_trigger_capture: RTL and testbench

- Consumes the 14-bit ADC word already synchronised into the SYS_CLK domain, one sample per clock.
- Stores samples in a circular buffer, detects a level/slope trigger, and freezes a window of pre-trigger and post-trigger samples.
- Host logic then reads the window out oldest-first through a request/valid handshake.
- Sits between the ADC sync stage and the readout/transfer logic.

---
 rtl/adc_trigger_capture.sv | 196 +++++++++++++++++++
 tb/tb_adc_trigger_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trigger_capture.sv
// ---------------------------------------------------------------------------
// adc_trigger_capture
// Continuously records synchronised ADC samples into a circular buffer. After
// ARM it records the pre-trigger history, waits for a level/slope (or forced)
// trigger, then records the remaining post-trigger samples. The frozen window
// is read out oldest-first through a request/valid handshake.
//
// Ports
//   SYS_CLK     in   system clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   DATA1       in   ADC sample, unsigned offset-binary, one per clock
//   ARM         in   capture start pulse (honoured in IDLE and READY)
//   FORCE_TRIG  in   unconditional trigger while waiting
//   TRIG_LEVEL  in   trigger threshold (latched on ARM)
//   TRIG_SLOPE  in   1 = rising, 0 = falling (latched on ARM)
//   PRE_TRIG    in   pre-trigger sample count (latched on ARM)
//   RD_REQ      in   read one window sample (honoured in READY only)
//   RD_DATA     out  read sample, one cycle after the request
//   RD_VALID    out  RD_DATA valid strobe
//   BUSY        out  capture in progress
//   READY       out  complete window held
//   TRIG_ADDR   out  buffer address of the trigger sample
// ---------------------------------------------------------------------------
module adc_trigger_capture #(
   parameter int unsigned DATA_W = 14,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              SYS_CLK,
   input  logic              RESET_N,
   input  logic [DATA_W-1:0] DATA1,
   input  logic              ARM,
   input  logic              FORCE_TRIG,
   input  logic [DATA_W-1:0] TRIG_LEVEL,
   input  logic              TRIG_SLOPE,
   input  logic [ADDR_W-1:0] PRE_TRIG,
   input  logic              RD_REQ,
   output logic [DATA_W-1:0] RD_DATA,
   output logic              RD_VALID,
   output logic              BUSY,
   output logic              READY,
   output logic [ADDR_W-1:0] TRIG_ADDR
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PRETRIG = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_POST    = 3'd3;
   localparam logic [2:0] S_READY   = 3'd4;

   localparam logic [ADDR_W-1:0] L_MAX = {ADDR_W{1'b1}};

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   // Shared down-counter: pre-trigger writes, post-trigger writes, then reads.
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] r_pre;
   logic [DATA_W-1:0] r_level;
   logic              r_slope;
   logic [DATA_W-1:0] r_prev;
   logic              r_prev_valid;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_busy;
   logic              r_ready;
   logic [ADDR_W-1:0] r_trig_addr;

   logic              w_wr_en;
   logic              w_rd_en;
   logic              w_arm_go;
   logic              w_trig;
   logic              w_slope_hit;
   logic              w_trig_hit;

   // Slope crossing between the previous written sample and the current one.
   assign w_slope_hit = r_slope ? ((r_prev <  r_level) && (DATA1 >= r_level))
                                : ((r_prev >= r_level) && (DATA1 <  r_level));
   assign w_trig_hit  = FORCE_TRIG || (r_prev_valid && w_slope_hit);

   // Next-state and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_rd_en     = 1'b0;
      w_arm_go    = 1'b0;
      w_trig      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ARM) begin
               w_arm_go    = 1'b1;
               w_state_nxt = (PRE_TRIG == '0) ? S_WAIT : S_PRETRIG;
            end
         end
         S_PRETRIG: begin
            w_wr_en = 1'b1;
            if (r_cnt == ADDR_W'(1)) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            w_wr_en = 1'b1;
            if (w_trig_hit) begin
               w_trig      = 1'b1;
               w_state_nxt = (r_pre == L_MAX) ? S_READY : S_POST;
            end
         end
         S_POST: begin
            w_wr_en = 1'b1;
            if (r_cnt == ADDR_W'(1)) w_state_nxt = S_READY;
         end
         S_READY: begin
            // A new ARM abandons the held window and takes priority over reads.
            if (ARM) begin
               w_arm_go    = 1'b1;
               w_state_nxt = (PRE_TRIG == '0) ? S_WAIT : S_PRETRIG;
            end else if (RD_REQ) begin
               w_rd_en = 1'b1;
               if (r_cnt == '0) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, pointers, trigger bookkeeping and registered outputs.
   always_ff @(posedge SYS_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_cnt        <= '0;
         r_pre        <= '0;
         r_level      <= '0;
         r_slope      <= 1'b0;
         r_prev       <= '0;
         r_prev_valid <= 1'b0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_ready      <= 1'b0;
         r_trig_addr  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_busy     <= (w_state_nxt == S_PRETRIG) || (w_state_nxt == S_WAIT) ||
                       (w_state_nxt == S_POST);
         r_ready    <= (w_state_nxt == S_READY);
         r_rd_valid <= w_rd_en;

         if (w_arm_go) begin
            r_level      <= TRIG_LEVEL;
            r_slope      <= TRIG_SLOPE;
            r_pre        <= PRE_TRIG;
            r_wr_ptr     <= '0;
            r_prev_valid <= 1'b0;
         end else if (w_wr_en) begin
            r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
            r_prev       <= DATA1;
            r_prev_valid <= 1'b1;
         end

         if (w_arm_go) begin
            r_cnt <= PRE_TRIG;
         end else if ((w_state_nxt == S_READY) && (r_state != S_READY)) begin
            r_cnt <= L_MAX;
         end else if (w_trig) begin
            r_cnt <= L_MAX - r_pre;
         end else if ((r_state == S_PRETRIG) || (r_state == S_POST) || w_rd_en) begin
            r_cnt <= r_cnt - ADDR_W'(1);
         end

         // Oldest window sample sits PRE_TRIG entries behind the trigger.
         if (w_trig) begin
            r_trig_addr <= r_wr_ptr;
            r_rd_ptr    <= r_wr_ptr - r_pre;
         end else if (w_rd_en) begin
            r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
         end

         if (w_rd_en) r_rd_data <= r_mem[r_rd_ptr];
      end
   end

   // Sample buffer write port; contents survive reset.
   always_ff @(posedge SYS_CLK) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= DATA1;
   end

   assign RD_DATA   = r_rd_data;
   assign RD_VALID  = r_rd_valid;
   assign BUSY      = r_busy;
   assign READY     = r_ready;
   assign TRIG_ADDR = r_trig_addr;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_trigger_capture
// Directed bench for adc_trigger_capture (ADDR_W=4, DEPTH=16). A sample-history
// model predicts every output each cycle; literal checks pin key results.
// ---------------------------------------------------------------------------
module tb_adc_trigger_capture;

   localparam int unsigned DATA_W = 14;
   localparam int unsigned ADDR_W = 4;
   localparam int          DEPTH  = 16;

   logic              SYS_CLK = 1'b0;
   logic              RESET_N = 1'b0;
   logic [DATA_W-1:0] DATA1 = '0;
   logic              ARM = 1'b0;
   logic              FORCE_TRIG = 1'b0;
   logic [DATA_W-1:0] TRIG_LEVEL = '0;
   logic              TRIG_SLOPE = 1'b0;
   logic [ADDR_W-1:0] PRE_TRIG = '0;
   logic              RD_REQ = 1'b0;
   logic [DATA_W-1:0] RD_DATA;
   logic              RD_VALID;
   logic              BUSY;
   logic              READY;
   logic [ADDR_W-1:0] TRIG_ADDR;

   int n_checks = 0;
   int n_errors = 0;

   adc_trigger_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .SYS_CLK(SYS_CLK), .RESET_N(RESET_N), .DATA1(DATA1), .ARM(ARM),
      .FORCE_TRIG(FORCE_TRIG), .TRIG_LEVEL(TRIG_LEVEL), .TRIG_SLOPE(TRIG_SLOPE),
      .PRE_TRIG(PRE_TRIG), .RD_REQ(RD_REQ), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
      .BUSY(BUSY), .READY(READY), .TRIG_ADDR(TRIG_ADDR)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: samples written since ARM; window = PRE_TRIG before trigger + DEPTH-PRE_TRIG from it.
   int          m_phase = 0;       // 0 idle, 1 capturing, 2 window held
   logic [13:0] m_hist[$];
   int          m_trig = -1;
   int          m_pre = 0;
   int          m_nread = 0;
   logic [13:0] m_lvl = '0;
   logic        m_slope = 1'b0;
   logic        e_busy = 1'b0, e_ready = 1'b0, e_valid = 1'b0;
   logic [13:0] e_data = '0;
   int          e_taddr = 0;

   function automatic bit crossing(input logic [13:0] p, input logic [13:0] c,
                                   input logic [13:0] lvl, input logic rising);
      if (rising) return (p < lvl) && (c >= lvl);
      return (p >= lvl) && (c < lvl);
   endfunction

   always @(posedge SYS_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         m_phase = 0; m_hist.delete(); m_trig = -1;
         e_busy = 0; e_ready = 0; e_valid = 0; e_data = '0; e_taddr = 0;
      end else begin
         e_valid = 0;
         if (ARM && (m_phase == 0 || m_phase == 2)) begin
            m_lvl = TRIG_LEVEL; m_slope = TRIG_SLOPE; m_pre = int'(PRE_TRIG);
            m_hist.delete(); m_trig = -1; m_phase = 1;
         end else if (m_phase == 1) begin
            int n;
            n = m_hist.size();
            if (m_trig < 0 && n >= m_pre) begin
               if (FORCE_TRIG || (n > 0 && crossing(m_hist[n-1], DATA1, m_lvl, m_slope))) begin
                  m_trig  = n;
                  e_taddr = n % DEPTH;
               end
            end
            m_hist.push_back(DATA1);
            if (m_trig >= 0 && m_hist.size() == m_trig + DEPTH - m_pre) begin
               m_phase = 2; m_nread = 0;
            end
         end else if (m_phase == 2 && RD_REQ) begin
            e_data  = m_hist[m_trig - m_pre + m_nread];
            e_valid = 1;
            m_nread++;
            if (m_nread == DEPTH) m_phase = 0;
         end
         e_busy  = (m_phase == 1);
         e_ready = (m_phase == 2);
      end
   end

   // Per-cycle comparison against the model; also logs read data.
   logic [13:0] rd_log[$];
   always @(posedge SYS_CLK) begin
      #1;
      chk("busy",      int'(BUSY),      int'(e_busy));
      chk("ready",     int'(READY),     int'(e_ready));
      chk("rd_valid",  int'(RD_VALID),  int'(e_valid));
      chk("rd_data",   int'(RD_DATA),   int'(e_data));
      chk("trig_addr", int'(TRIG_ADDR), e_taddr);
      if (RD_VALID) rd_log.push_back(RD_DATA);
   end

   task automatic drive(input int d, input logic arm, input logic frc, input logic rd);
      DATA1 = 14'(d); ARM = arm; FORCE_TRIG = frc; RD_REQ = rd;
      @(negedge SYS_CLK);
   endtask

   task automatic setup(input int lvl, input logic slope, input int pre);
      TRIG_LEVEL = 14'(lvl); TRIG_SLOPE = slope; PRE_TRIG = 4'(pre);
   endtask

   task automatic read_n(input int n);
      rd_log.delete();
      for (int i = 0; i < n; i++) drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
   endtask

   initial begin
      @(negedge SYS_CLK);
      @(negedge SYS_CLK);
      chk("reset_busy", int'(BUSY), 0);
      chk("reset_ready", int'(READY), 0);
      chk("reset_taddr", int'(TRIG_ADDR), 0);
      RESET_N = 1'b1;
      drive(0, 0, 0, 0);

      // 1: rising, level 100, pre 4, ramp from 90
      setup(100, 1, 4);
      drive(0, 1, 0, 0);
      for (int i = 0; i < 21; i++) drive(90 + i, 0, 0, 0);
      chk("t1_not_ready_early", int'(READY), 0);
      drive(111, 0, 0, 0);
      chk("t1_ready", int'(READY), 1);
      chk("t1_taddr", int'(TRIG_ADDR), 10);
      read_n(16);
      chk("t1_nreads", rd_log.size(), 16);
      if (rd_log.size() == 16) begin
         chk("t1_first", int'(rd_log[0]), 96);
         chk("t1_last", int'(rd_log[15]), 111);
      end
      chk("t1_ready_done", int'(READY), 0);

      // 2: falling, level 50, pre 0; stale prev (111) must not trigger
      setup(50, 0, 0);
      drive(0, 1, 0, 0);
      chk("t2_busy", int'(BUSY), 1);
      drive(40, 0, 0, 0);
      drive(40, 0, 0, 0);
      drive(40, 0, 0, 0);
      drive(60, 0, 0, 0);
      drive(40, 0, 0, 0);
      chk("t2_taddr", int'(TRIG_ADDR), 4);
      for (int i = 0; i < 15; i++) drive(200 + i, 0, 0, 0);
      chk("t2_ready", int'(READY), 1);
      read_n(16);
      chk("t2_nreads", rd_log.size(), 16);
      if (rd_log.size() == 16) begin
         chk("t2_first", int'(rd_log[0]), 40);
         chk("t2_second", int'(rd_log[1]), 200);
      end

      // 3+4: pre 15, wrap in WAIT, forced trigger, 20 back-to-back requests
      setup(0, 1, 15);
      drive(0, 1, 0, 0);
      for (int i = 0; i < 15; i++) drive(500 + i, 0, 0, 0);
      for (int i = 0; i < 40; i++) drive(0, 0, 0, 0);
      chk("t3_waiting", int'(BUSY), 1);
      drive(777, 0, 1, 0);
      chk("t3_ready", int'(READY), 1);
      chk("t3_taddr", int'(TRIG_ADDR), 7);
      rd_log.delete();
      for (int i = 0; i < 20; i++) drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      chk("t4_nreads", rd_log.size(), 16);
      if (rd_log.size() == 16) begin
         chk("t3_first", int'(rd_log[0]), 0);
         chk("t3_last", int'(rd_log[15]), 777);
      end
      chk("t4_ready_done", int'(READY), 0);

      // 5: ARM ignored in WAIT/POST; ARM+RD_REQ in READY restarts
      setup(1000, 1, 2);
      drive(0, 1, 0, 0);
      for (int i = 0; i < 24; i++) drive(990 + i, (i == 5) || (i == 15), 0, 0);
      chk("t5_ready", int'(READY), 1);
      chk("t5_taddr", int'(TRIG_ADDR), 10);
      rd_log.delete();
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 1);
      setup(0, 1, 3);
      drive(0, 1, 0, 1);
      chk("t5_partial", rd_log.size(), 5);
      if (rd_log.size() == 5) chk("t5_first_old", int'(rd_log[0]), 998);
      chk("t5_arm_wins", int'(RD_VALID), 0);
      chk("t5_rearmed", int'(BUSY), 1);
      for (int i = 0; i < 3; i++) drive(300 + i, 0, 0, 0);
      drive(303, 0, 1, 0);
      for (int i = 0; i < 12; i++) drive(304 + i, 0, 0, 0);
      read_n(16);
      chk("t5_nreads", rd_log.size(), 16);
      if (rd_log.size() == 16) begin
         chk("t5_first", int'(rd_log[0]), 300);
         chk("t5_last", int'(rd_log[15]), 315);
      end

      // 6: reset during POST, then a clean capture
      setup(2000, 0, 5);
      drive(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) drive(10 + i, 0, 0, 0);
      drive(15, 0, 1, 0);
      for (int i = 0; i < 3; i++) drive(16 + i, 0, 0, 0);
      RESET_N = 1'b0;
      drive(0, 0, 0, 0);
      chk("t6_busy", int'(BUSY), 0);
      chk("t6_ready", int'(READY), 0);
      chk("t6_rd_data", int'(RD_DATA), 0);
      chk("t6_taddr", int'(TRIG_ADDR), 0);
      RESET_N = 1'b1;
      drive(0, 0, 0, 0);
      setup(120, 1, 5);
      drive(0, 1, 0, 0);
      for (int i = 0; i < 21; i++) drive(110 + i, 0, 0, 0);
      chk("t6_ready_after", int'(READY), 1);
      chk("t6_taddr_after", int'(TRIG_ADDR), 10);
      read_n(16);
      chk("t6_nreads", rd_log.size(), 16);
      if (rd_log.size() == 16) begin
         chk("t6_first", int'(rd_log[0]), 115);
         chk("t6_last", int'(rd_log[15]), 130);
      end

      drive(0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
